// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte-stream and instruction-memory write bundle for im_loader
//
// Purpose: groups the host byte stream, the start/status levels and the
// instruction-memory byte write port of the program loader.
//
// Signals:
//   startIn      host -> loader  begin a load (single-cycle pulse)
//   byteIn       host -> loader  stream byte
//   byteValidIn  host -> loader  byteIn is valid
//   byteRdyOut   loader -> host  loader accepts a byte this cycle
//   imWrEnOut    loader -> mem   byte write strobe
//   imWrAddrOut  loader -> mem   byte address (BUS_W bits)
//   imWrDataOut  loader -> mem   byte written
//   cpuHoldOut   loader -> core  stall fetch/PC
//   doneOut      loader -> host  clean load finished
//   errOut       loader -> host  load aborted
//
// Modports: master = host/bench side, slave = loader side.

interface im_loader_if #(
  parameter int BUS_W = 32
);
  logic             startIn;
  logic [7:0]       byteIn;
  logic             byteValidIn;
  logic             byteRdyOut;
  logic             imWrEnOut;
  logic [BUS_W-1:0] imWrAddrOut;
  logic [7:0]       imWrDataOut;
  logic             cpuHoldOut;
  logic             doneOut;
  logic             errOut;

  modport master (
    output startIn,
    output byteIn,
    output byteValidIn,
    input  byteRdyOut,
    input  imWrEnOut,
    input  imWrAddrOut,
    input  imWrDataOut,
    input  cpuHoldOut,
    input  doneOut,
    input  errOut
  );

  modport slave (
    input  startIn,
    input  byteIn,
    input  byteValidIn,
    output byteRdyOut,
    output imWrEnOut,
    output imWrAddrOut,
    output imWrDataOut,
    output cpuHoldOut,
    output doneOut,
    output errOut
  );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream loader into the instruction memory write port
//
// Purpose: accepts a frame {len[7:0], len[15:8], payload[len], csum} from a
// byte source, writes payload byte i to instruction-memory address i, checks
// an 8-bit additive checksum and releases the core only on a clean load.
//
// Parameters:
//   MEM_SIZE  instruction memory size in bytes; largest accepted payload
//   BUS_W     width of the memory byte address (must match the interface)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    im_loader_if.slave: byte stream in, memory write port and status out

module im_loader #(
  parameter int MEM_SIZE = 128,
  parameter int BUS_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  im_loader_if.slave    bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  // One extra bit so MEM_SIZE = 65536 still compares correctly.
  localparam logic [16:0] MAX_LEN = 17'(MEM_SIZE);

  logic [2:0]       state_q,   state_d;
  logic [15:0]      len_q,     len_d;
  logic [15:0]      index_q,   index_d;
  logic [7:0]       csum_q,    csum_d;
  logic             wr_en_q,   wr_en_d;
  logic [BUS_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic        byte_rdy;
  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic [7:0]  csum_next;
  logic        last_byte;

  always_comb begin
    byte_rdy  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    start_ok  = bus.startIn &&
                ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    accept    = bus.byteValidIn && byte_rdy;
    // Length as it will be once the high byte currently on the bus is taken.
    len_full  = {bus.byteIn, len_q[7:0]};
    csum_next = csum_q + bus.byteIn;
    last_byte = (index_q == (len_q - 16'd1));
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    index_d   = index_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          state_d = S_LEN0;
          len_d   = 16'd0;
          index_d = 16'd0;
          csum_d  = 8'd0;
        end
      end

      S_LEN0: begin
        if (accept) begin
          len_d   = {8'd0, bus.byteIn};
          state_d = S_LEN1;
        end
      end

      S_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BUS_W'(index_q);
          wr_data_d = bus.byteIn;
          csum_d    = csum_next;
          index_d   = index_q + 16'd1;
          if (last_byte) begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          state_d = (bus.byteIn == csum_q) ? S_DONE : S_ERR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      index_q   <= 16'd0;
      csum_q    <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      index_q   <= index_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Status is pure state decode: it changes at the edge that accepts the
  // deciding byte. ERR keeps the core held so a partial image never runs.
  assign bus.byteRdyOut  = byte_rdy;
  assign bus.imWrEnOut   = wr_en_q;
  assign bus.imWrAddrOut = wr_addr_q;
  assign bus.imWrDataOut = wr_data_q;
  assign bus.doneOut     = (state_q == S_DONE);
  assign bus.errOut      = (state_q == S_ERR);
  assign bus.cpuHoldOut  = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: doc/im_loader.md
# im_loader

Byte-stream program loader that writes a framed binary image into the instruction memory's byte-wide write port while holding the core in fetch-stall. It sits between a host-side byte source (UART receiver, JTAG bridge, or testbench) and the instruction memory, and is the write-side counterpart of the memory's combinational little-endian word read. A frame carries a 16-bit byte count, the payload, and an 8-bit additive checksum. The loader reports done or error and releases the core only on a clean load.

## Interface
- `MEM_SIZE`, default 128: instruction memory size in bytes; upper bound on payload length.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `startIn`  in  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- `byteIn`  in  8  incoming stream byte.
- `byteValidIn`  in  1  `byteIn` is valid.
- `byteRdyOut`  out  1  loader accepts a byte this cycle.
- `imWrEnOut`  out  1  instruction-memory byte write strobe.
- `imWrAddrOut`  out  `BUS_W`  byte address of the write.
- `imWrDataOut`  out  8  byte written.
- `cpuHoldOut`  out  1  stall fetch/PC while loading.
- `doneOut`  out  1  load finished and checksum matched (level).
- `errOut`  out  1  load aborted (level).

## Operation
- **Handshake.** A byte is accepted on a rising edge where `byteValidIn && byteRdyOut`. `byteRdyOut` is registered-state decode and is high exactly in LEN0, LEN1, DATA and CSUM. `byteValidIn` gaps are legal; no byte is lost or duplicated.
- **IDLE.** `startIn` moves to LEN0. At the same edge `cpuHoldOut` goes to 1, `doneOut` and `errOut` go to 0, the checksum is cleared and the index is cleared.
- **LEN0.** On accept, `len[7:0]` is loaded; go to LEN1.
- **LEN1.** On accept, `len[15:8]` is loaded. Then:
  - full 16-bit `len > MEM_SIZE` goes to ERR;
  - `len == 0` goes to CSUM;
  - otherwise go to DATA.
- **DATA.** On each accept:
  - register a write with `imWrAddrOut = index`, `imWrDataOut = byteIn`, and `imWrEnOut = 1` for exactly one cycle;
  - update `csum = csum + byteIn` (8-bit, wraps mod 256);
  - increment `index`, which is 16 bits wide and zero-extended to `BUS_W` on `imWrAddrOut`;
  - when the accepted byte is the last one (`index == len-1`), go to CSUM.
- **CSUM.** On accept, compare `byteIn` with `csum`. Equal goes to DONE; unequal goes to ERR.
- **DONE.** `doneOut` = 1 and `cpuHoldOut` = 0. `startIn` restarts at LEN0.
- **ERR.** `errOut` = 1 and `cpuHoldOut` stays 1, so a partial image never runs. `startIn` restarts at LEN0.
- **Start while busy.** `startIn` in LEN0, LEN1, DATA or CSUM is ignored.
- **Byte while not ready.** `byteValidIn` in IDLE, DONE or ERR is ignored; `byteRdyOut` is 0 there.
- **Memory write port.** Only bytes 0..`len-1` are written. Bytes beyond `len` keep their previous contents.

## Timing
- **Reset values.** State IDLE, `byteRdyOut` 0, `imWrEnOut` 0, `imWrAddrOut` 0, `imWrDataOut` 0, `cpuHoldOut` 0, `doneOut` 0, `errOut` 0, `len` 0, `index` 0, `csum` 0.
- **Reset mid-load.** Returns to IDLE with the values above. Memory contents already written are not undone.
- **Write latency.** The write appears one cycle after the accepting edge and is committed by the memory at the following edge.
- **Back-to-back bytes.** One byte per cycle sustained in every ready state; writes are one per cycle with no bubbles.
- **Start latency.** `startIn` edge to first `byteRdyOut` = 1 cycle (LEN0 is entered at that edge).
- **Status latency.** DONE/ERR and their outputs assert at the edge that accepts the deciding byte, which is the LEN1 byte or the CSUM byte.
- **Frame duration.** Minimum total for a `len`-byte frame with no gaps is `len + 3` accept cycles after the start edge.

## Test plan
- **Clean load.** Start, then stream 0C 00 13 05 50 00 93 85 15 00 6F F6 DF FF D8 with no gaps. Expect:
  - 12 writes to addresses 0..11 carrying those payload bytes;
  - reading word 8 returns 0xFFDFF66F;
  - `doneOut` = 1, `cpuHoldOut` = 0, `errOut` = 0.
- **Bad checksum.** Same frame with checksum D9. Expect all 12 writes to occur, then `errOut` = 1, `cpuHoldOut` = 1, `doneOut` = 0.
- **Oversize length.** Length 81 00 (129). Expect ERR after the second byte, no `imWrEnOut` pulse, and `byteRdyOut` = 0.
- **Zero length.** Stream 00 00 00. Expect DONE with no writes. Stream 00 00 01 instead and expect ERR.
- **Gaps and ignored start.** Clean frame with random 0-3 cycle `byteValidIn` gaps and a `startIn` pulse injected mid-DATA. Expect identical memory image, DONE, and the start pulse ignored.
- **Reset mid-load.** Assert `rst_n` low after payload byte 5 for 2 cycles. Expect all outputs at reset values and IDLE. A following clean load completes with DONE.
